// File: rtl/micro_sequencer.sv
// Microcode sequencer for the multicycle MIPS datapath: 14-word store, micro-PC, two dispatch tables.
// Controls decode combinationally from upc. Memory microsteps hold upc until mem_ready.
module micro_sequencer #(
    parameter int CNT_W = 32,
    parameter int UPC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             IRWrite,
    output logic             ALUSrcA,
    output logic             PCWriteCond,
    output logic             BranchNotEqual,
    output logic             PCWrite,
    output logic             IorD,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSrc,
    output logic [1:0]       ALUOp,
    output logic [UPC_W-1:0] upc,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [UPC_W-1:0] {
        FETCH   = 0,  DECODE  = 1,  MEMADR  = 2,  LW_MEM  = 3,
        LW_WB   = 4,  SW_MEM  = 5,  R_EXE   = 6,  R_WB    = 7,
        BEQ     = 8,  BNE     = 9,  JUMP    = 10, ADDI_EX = 11,
        ADDI_WB = 12, JAL     = 13
    } uword_t;

    uword_t           r_upc;
    uword_t           w_upc_nxt;
    logic [UPC_W-1:0] w_dec;
    logic [CNT_W-1:0] r_instr_count;
    logic [CNT_W-1:0] r_cycle_count;

    // Decoding an all-ones word during reset forces every control low.
    assign w_dec       = rst ? '1 : r_upc;
    assign upc         = r_upc;
    assign instr_count = r_instr_count;
    assign cycle_count = r_cycle_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_upc         <= FETCH;
            r_instr_count <= '0;
            r_cycle_count <= '0;
        end else begin
            r_upc         <= w_upc_nxt;
            r_cycle_count <= r_cycle_count + CNT_W'(1);
            if (instr_done)
                r_instr_count <= r_instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0; IRWrite = 1'b0;
        ALUSrcA = 1'b0; PCWriteCond = 1'b0; BranchNotEqual = 1'b0;
        PCWrite = 1'b0; IorD = 1'b0;
        RegDst = 2'b00; MemtoReg = 2'b00; ALUSrcB = 2'b00; PCSrc = 2'b00; ALUOp = 2'b00;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        w_upc_nxt  = FETCH;
        case (w_dec)
            FETCH: begin
                MemRead   = 1'b1;
                ALUSrcB   = 2'b01;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                w_upc_nxt = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    6'b000000:            w_upc_nxt = R_EXE;
                    6'b100011, 6'b101011: w_upc_nxt = MEMADR;
                    6'b000100:            w_upc_nxt = BEQ;
                    6'b000101:            w_upc_nxt = BNE;
                    6'b000010:            w_upc_nxt = JUMP;
                    6'b001000:            w_upc_nxt = ADDI_EX;
                    6'b000011:            w_upc_nxt = JAL;
                    default:              illegal_op = 1'b1;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (opcode == 6'b100011)      w_upc_nxt = LW_MEM;
                else if (opcode == 6'b101011) w_upc_nxt = SW_MEM;
            end
            LW_MEM: begin
                MemRead   = 1'b1;
                IorD      = 1'b1;
                w_upc_nxt = mem_ready ? LW_WB : LW_MEM;
            end
            LW_WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 2'b01;
                instr_done = 1'b1;
            end
            SW_MEM: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
                w_upc_nxt  = mem_ready ? FETCH : SW_MEM;
            end
            R_EXE: begin
                ALUSrcA   = 1'b1;
                ALUOp     = 2'b10;
                w_upc_nxt = R_WB;
            end
            R_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 2'b01;
                instr_done = 1'b1;
            end
            BEQ, BNE: begin
                ALUSrcA        = 1'b1;
                ALUOp          = 2'b01;
                PCWriteCond    = 1'b1;
                PCSrc          = 2'b01;
                BranchNotEqual = (w_dec == BNE);
                instr_done     = 1'b1;
            end
            JUMP: begin
                PCWrite    = 1'b1;
                PCSrc      = 2'b10;
                instr_done = 1'b1;
            end
            ADDI_EX: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                w_upc_nxt = ADDI_WB;
            end
            ADDI_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            JAL: begin
                PCWrite    = 1'b1;
                PCSrc      = 2'b10;
                RegWrite   = 1'b1;
                RegDst     = 2'b10;
                MemtoReg   = 2'b10;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: instruction-level model (microstep paths + per-word control table).
module tb_micro_sequencer;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010,
                           OP_ADDI = 6'b001000, OP_JAL = 6'b000011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = 6'b0;
    logic        mem_ready = 1'b1;
    logic        MemRead, MemWrite, RegWrite, IRWrite, ALUSrcA, PCWriteCond;
    logic        BranchNotEqual, PCWrite, IorD;
    logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSrc, ALUOp;
    logic [3:0]  upc;
    logic        instr_done, illegal_op;
    logic [31:0] instr_count, cycle_count;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cyc = 0;
    logic [31:0] exp_ins = 0;

    micro_sequencer dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
        .ALUSrcA(ALUSrcA), .PCWriteCond(PCWriteCond), .BranchNotEqual(BranchNotEqual),
        .PCWrite(PCWrite), .IorD(IorD), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUOp(ALUOp), .upc(upc),
        .instr_done(instr_done), .illegal_op(illegal_op),
        .instr_count(instr_count), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    wire [22:0] obs = {MemRead, MemWrite, RegWrite, IRWrite, ALUSrcA, PCWriteCond,
                       BranchNotEqual, PCWrite, IorD, RegDst, MemtoReg, ALUSrcB,
                       PCSrc, ALUOp, instr_done, illegal_op};

    // {MemRead MemWrite RegWrite IRWrite ALUSrcA PCWriteCond BNE PCWrite IorD, RegDst MemtoReg ALUSrcB PCSrc ALUOp}
    function automatic logic [20:0] exp_ctl(input int w, input logic mr);
        case (w)
            0:  exp_ctl = {1'b1, 2'b00, mr, 3'b000, mr, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
            1:  exp_ctl = {9'b000000000, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00};
            2:  exp_ctl = {9'b000010000, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
            3:  exp_ctl = {9'b100000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
            4:  exp_ctl = {9'b001000000, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
            5:  exp_ctl = {9'b010000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
            6:  exp_ctl = {9'b000010000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
            7:  exp_ctl = {9'b001000000, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
            8:  exp_ctl = {9'b000011000, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
            9:  exp_ctl = {9'b000011100, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
            10: exp_ctl = {9'b000000010, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
            11: exp_ctl = {9'b000010000, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
            12: exp_ctl = {9'b001000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
            13: exp_ctl = {9'b001000010, 2'b10, 2'b10, 2'b00, 2'b10, 2'b00};
            default: exp_ctl = '0;
        endcase
    endfunction

    // Runs one instruction from FETCH; wf/wm = stall cycles at FETCH and at the memory step.
    // Returns the number of observed PCWrite cycles. Entered and left just after a falling edge.
    task automatic run_instr(input logic [5:0] op, input int wf, input int wm, output int pcw);
        int   path[$];
        bit   legal;
        logic mr;
        logic exp_done, exp_ill;
        legal = 1'b1;
        case (op)
            OP_LW:              path = {0, 1, 2, 3, 4};
            OP_SW:              path = {0, 1, 2, 5};
            OP_R:               path = {0, 1, 6, 7};
            OP_BEQ:             path = {0, 1, 8};
            OP_BNE:             path = {0, 1, 9};
            OP_J:               path = {0, 1, 10};
            OP_ADDI:            path = {0, 1, 11, 12};
            OP_JAL:             path = {0, 1, 13};
            default: begin      path = {0, 1}; legal = 1'b0; end
        endcase
        pcw = 0;
        for (int i = 0; i < path.size(); i++) begin
            int  w;
            int  k;
            bit  is_w;
            w    = path[i];
            is_w = (w == 0) || (w == 3) || (w == 5);
            k    = !is_w ? 0 : (w == 0 ? wf : wm);
            for (int c = 0; c <= k; c++) begin
                mr        = is_w ? (c == k) : 1'($urandom);
                opcode    = op;
                mem_ready = mr;
                #1;
                exp_done = (i == path.size() - 1) && legal && (!is_w || mr);
                exp_ill  = (w == 1) && !legal;
                checks++;
                if (upc !== 4'(w)) begin
                    errors++;
                    $display("FAIL upc op=%b step=%0d: got %0d want %0d", op, i, upc, w);
                end
                checks++;
                if (obs !== {exp_ctl(w, mr), exp_done, exp_ill}) begin
                    errors++;
                    $display("FAIL controls op=%b upc=%0d mr=%b: got %b want %b",
                             op, w, mr, obs, {exp_ctl(w, mr), exp_done, exp_ill});
                end
                checks++;
                if (instr_count !== exp_ins || cycle_count !== exp_cyc) begin
                    errors++;
                    $display("FAIL counters op=%b upc=%0d: got ins=%0d cyc=%0d want ins=%0d cyc=%0d",
                             op, w, instr_count, cycle_count, exp_ins, exp_cyc);
                end
                if (PCWrite) pcw++;
                @(negedge clk);
                exp_cyc++;
                if (exp_done) exp_ins++;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (obs !== 23'd0 || upc !== 4'd0 || instr_count !== 0 || cycle_count !== 0) begin
                errors++;
                $display("FAIL reset_hold: got ctl=%b upc=%0d ins=%0d cyc=%0d want all 0",
                         obs, upc, instr_count, cycle_count);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        exp_cyc = 0;
        exp_ins = 0;
        #1;
        checks++;
        if (upc !== 4'd0 || PCWrite !== 1'b1 || IRWrite !== 1'b1 || MemRead !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got upc=%0d PCWrite=%b IRWrite=%b MemRead=%b want 0 1 1 1",
                     upc, PCWrite, IRWrite, MemRead);
        end
    endtask

    task automatic test_lw;
        int pcw;
        run_instr(OP_LW, 0, 0, pcw);
        checks++;
        if (instr_count !== 32'd1 || cycle_count !== 32'd5) begin
            errors++;
            $display("FAIL lw_counts: got ins=%0d cyc=%0d want 1 5", instr_count, cycle_count);
        end
    endtask

    task automatic test_lw_stall;
        int          pcw;
        logic [31:0] c0;
        c0 = cycle_count;
        run_instr(OP_LW, 2, 2, pcw);
        checks++;
        if (cycle_count - c0 !== 32'd9 || pcw != 1) begin
            errors++;
            $display("FAIL lw_stall: got cycles=%0d pcwrite=%0d want 9 1", cycle_count - c0, pcw);
        end
    endtask

    task automatic test_back_to_back;
        int          pcw;
        logic [31:0] i0;
        i0 = instr_count;
        run_instr(OP_R,   0, 0, pcw);
        run_instr(OP_BNE, 0, 0, pcw);
        run_instr(OP_JAL, 0, 0, pcw);
        checks++;
        if (instr_count - i0 !== 32'd3 || pcw != 2) begin
            errors++;
            $display("FAIL back_to_back: got retired=%0d jal_pcwrite=%0d want 3 2", instr_count - i0, pcw);
        end
    endtask

    task automatic test_illegal;
        int          pcw;
        logic [31:0] i0;
        i0 = instr_count;
        run_instr(6'b111111, 0, 0, pcw);
        run_instr(6'b010000, 1, 0, pcw);
        checks++;
        if (instr_count !== i0 || upc !== 4'd0) begin
            errors++;
            $display("FAIL illegal_uncounted: got ins=%0d upc=%0d want %0d 0", instr_count, upc, i0);
        end
    endtask

    task automatic test_random;
        logic [5:0] ops[10];
        int         pcw;
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_JAL, 6'b111111, 6'b011100};
        for (int n = 0; n < 60; n++)
            run_instr(ops[$urandom_range(9, 0)], $urandom_range(2, 0), $urandom_range(3, 0), pcw);
    endtask

    task automatic test_async_reset;
        int pcw;
        opcode = OP_LW;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        #2;
        checks++;
        if (upc !== 4'd3) begin
            errors++;
            $display("FAIL async_setup: got upc=%0d want 3", upc);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (upc !== 4'd0 || obs !== 23'd0 || instr_count !== 0 || cycle_count !== 0) begin
            errors++;
            $display("FAIL async_reset: got upc=%0d ctl=%b ins=%0d cyc=%0d want all 0",
                     upc, obs, instr_count, cycle_count);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_cyc = 0;
        exp_ins = 0;
        run_instr(OP_SW, 1, 1, pcw);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lw_stall();
        test_back_to_back();
        test_illegal();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
